// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - Shared state type, table geometry and core pin levels for the CORDIC sequencer.
package cordic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int LUT_DEPTH = 64;
  localparam int LUT_W     = 48;
  localparam int AMP_W     = 16;
  localparam int IDX_W     = 6;

  // The core's reset, clock enable and LUT write enable are all active-low.
  localparam logic CORE_RST_ON  = 1'b0;
  localparam logic CORE_RST_OFF = 1'b1;
  localparam logic CORE_CEN_ON  = 1'b0;
  localparam logic CORE_CEN_OFF = 1'b1;
  localparam logic CORE_WEN_ON  = 1'b0;
  localparam logic CORE_WEN_OFF = 1'b1;

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// rtl/cordic_seq_ctrl_if.sv - Control/data bundle between the sequencer and the CORDIC_16_pipe core.
interface cordic_seq_ctrl_if;
  import cordic_ctrl_pkg::*;

  logic             core_rst_n;
  logic             core_cen;
  logic             core_wen;
  logic [IDX_W-1:0] core_index;
  logic [LUT_W-1:0] core_d;
  logic [AMP_W-1:0] core_fcw;
  logic [AMP_W-1:0] core_offset;
  logic [AMP_W-1:0] core_amp;
  logic             core_wen_out;

  modport master (
    output core_rst_n, core_cen, core_wen, core_index, core_d, core_fcw, core_offset,
    input  core_amp, core_wen_out
  );

  modport slave (
    input  core_rst_n, core_cen, core_wen, core_index, core_d, core_fcw, core_offset,
    output core_amp, core_wen_out
  );

endinterface

// File: rtl/cordic_lut_walker.sv
// rtl/cordic_lut_walker.sv - Walks the ROM once per load and realigns address with the 1-cycle ROM latency.
module cordic_lut_walker
  import cordic_ctrl_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int W     = LUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [W-1:0]     rom_data,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [W-1:0]     wr_data,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic issued_all;
  logic issue;

  assign issue = en && !issued_all;

  // wr_idx/wr_en trail rom_addr by one cycle so they line up with rom_data.
  always_ff @(posedge clk) begin
    if (reset || clr || !en) begin
      rom_addr   <= '0;
      issued_all <= 1'b0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
    end else begin
      wr_en  <= issue;
      wr_idx <= rom_addr;
      if (issue) begin
        rom_addr <= rom_addr + 1'b1;
        if (rom_addr == LAST_IDX) begin
          issued_all <= 1'b1;
        end
      end
    end
  end

  assign wr_data = wr_en ? rom_data : '0;
  assign last    = wr_en && (wr_idx == LAST_IDX);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - Load/flush/run/capture sequencer for the pipelined CORDIC sine core.
module cordic_seq_ctrl #(
  parameter int NUM_SAMPLES = 4096,
  parameter int LUT_DEPTH   = 64,
  parameter int LUT_W       = 48
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              skip_load,
  input  logic [15:0]                       fcw_in,
  input  logic [15:0]                       offset_in,
  input  logic                              cfg_we,
  output logic [cordic_ctrl_pkg::IDX_W-1:0] lut_addr,
  input  logic [LUT_W-1:0]                  lut_rdata,
  cordic_seq_ctrl_if.master                 core,
  output logic                              sample_valid,
  output logic [15:0]                       sample_data,
  output logic                              busy,
  output logic                              done
);
  import cordic_ctrl_pkg::*;

  localparam logic [15:0] N_SAMP = 16'(NUM_SAMPLES);

  state_t           state;
  state_t           state_nx;
  logic [15:0]      cnt;
  logic             lut_loaded;
  logic             live_nx;
  logic             rst_rel_nx;
  logic             launch;
  logic             retune;
  logic             capture;
  logic             wr_en;
  logic             wr_last;
  logic [IDX_W-1:0] wr_idx;
  logic [LUT_W-1:0] wr_data;

  cordic_lut_walker #(
    .DEPTH (LUT_DEPTH),
    .W     (LUT_W)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .en       (state == ST_LOAD),
    .clr      (abort),
    .rom_addr (lut_addr),
    .rom_data (lut_rdata),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .last     (wr_last)
  );

  assign core.core_wen   = wr_en ? CORE_WEN_ON : CORE_WEN_OFF;
  assign core.core_index = wr_idx;
  assign core.core_d     = wr_data;

  assign launch  = !abort && start && ((state == ST_IDLE) || (state == ST_DONE));
  assign retune  = !abort && cfg_we && (state == ST_RUN);
  // Once the count is reached, RUN lingers one cycle so done follows the last strobe.
  assign capture = !abort && core.core_wen_out && (state == ST_RUN) && (cnt != N_SAMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nx = (skip_load && lut_loaded) ? ST_FLUSH : ST_LOAD;
        ST_LOAD:          if (wr_last) state_nx = ST_FLUSH;
        ST_FLUSH:         state_nx = ST_RUN;
        ST_RUN:           if (cnt == N_SAMP) state_nx = ST_DONE;
        default:          state_nx = ST_IDLE;
      endcase
    end
    live_nx    = (state_nx == ST_LOAD) || (state_nx == ST_FLUSH) || (state_nx == ST_RUN);
    rst_rel_nx = (state_nx == ST_LOAD) || (state_nx == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      core.core_rst_n  <= CORE_RST_ON;
      core.core_cen    <= CORE_CEN_OFF;
      core.core_fcw    <= '0;
      core.core_offset <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sample_valid     <= 1'b0;
      sample_data      <= '0;
      cnt              <= '0;
      lut_loaded       <= 1'b0;
    end else begin
      core.core_rst_n <= rst_rel_nx ? CORE_RST_OFF : CORE_RST_ON;
      core.core_cen   <= live_nx ? CORE_CEN_ON : CORE_CEN_OFF;
      busy            <= live_nx;
      done            <= (state_nx == ST_DONE);
      sample_valid    <= capture;
      if (capture) begin
        sample_data <= core.core_amp;
      end
      if (abort || (state_nx == ST_FLUSH)) begin
        cnt <= '0;
      end else if (capture) begin
        cnt <= cnt + 16'd1;
      end
      if (launch || retune) begin
        core.core_fcw    <= fcw_in;
        core.core_offset <= offset_in;
      end
      if (abort && (state == ST_LOAD)) begin
        lut_loaded <= 1'b0;
      end else if (wr_last && !abort) begin
        lut_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencer for the 16-bit pipelined CORDIC sine core. On `start` it walks the 64-entry × 48-bit angle/gain table from a synchronous ROM into the core's LUT write port. It then pulses the core reset, applies the tuning word and phase offset, and captures a fixed number of output samples. It sits between the system control plane (start/abort/config) and `CORDIC_16_pipe`, and replaces hand-sequenced load/reset/run control.

## Interface
Parameters:
- `NUM_SAMPLES`, 4096: samples captured per run; range 1..65535.
- `LUT_DEPTH`, 64: table entries; must be 64, matching the core's 6-bit index.
- `LUT_W`, 48: table word width.

Ports:
- `clk`  in  1  single clock for the controller and the core.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin sequence; honoured only in IDLE or DONE.
- `abort`  in  1  return to IDLE from any state.
- `skip_load`  in  1  sampled with `start`: bypass LOAD if the table is already loaded.
- `fcw_in`  in  16  frequency control word.
- `offset_in`  in  16  phase offset.
- `cfg_we`  in  1  live retune: latch `fcw_in`/`offset_in`.
- `lut_addr`  out  6  ROM address.
- `lut_rdata`  in  48  ROM data, valid 1 cycle after `lut_addr`.
- `core_rst_n`  out  1  core reset, active-low.
- `core_cen`  out  1  core clock enable, active-low.
- `core_wen`  out  1  core LUT write enable, active-low.
- `core_index`  out  6  core LUT write index.
- `core_d`  out  48  core LUT write data.
- `core_fcw`  out  16  to core `fcw`.
- `core_offset`  out  16  to core `offset`.
- `core_amp`  in  16  core `sin_amp`.
- `core_wen_out`  in  1  core output-valid.
- `sample_valid`  out  1  captured-sample strobe.
- `sample_data`  out  16  captured sample.
- `busy`  out  1  high in LOAD, FLUSH and RUN.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE:
  - Outputs: `core_rst_n`=0, `core_cen`=1, `core_wen`=1, `busy`=0, `done`=0.
  - On `start`, latch `fcw_in`/`offset_in` into `core_fcw`/`core_offset`.
  - Go to FLUSH if `skip_load`=1 and `lut_loaded`=1; otherwise go to LOAD.
- LOAD:
  - `lut_addr` counts 0..63, one per cycle. A 1-cycle delayed copy drives `core_index`; `core_d`=`lut_rdata`.
  - `core_wen`=0 only while delayed data is valid: 64 write cycles, indices 0..63, in order.
  - `core_rst_n`=1, `core_cen`=0.
  - After the write of index 63: set `lut_loaded`, go to FLUSH.
- FLUSH: exactly 1 cycle, `core_rst_n`=0, `core_wen`=1, `core_cen`=0. Then go to RUN.
- RUN:
  - `core_rst_n`=1, `core_wen`=1, `core_cen`=0.
  - Each cycle with `core_wen_out`=1: register `core_amp` into `sample_data`, pulse `sample_valid`, increment the 16-bit sample counter.
  - When the counter reaches `NUM_SAMPLES`, go to DONE. That final sample is still emitted.
  - `cfg_we`=1 updates `core_fcw`/`core_offset` next cycle; no reload or flush.
- DONE: `core_cen`=1 (core frozen), `done`=1. `start` restarts with the same rules as IDLE.
- `abort` in any state: go to IDLE next cycle, sample counter cleared.
  - `abort` during LOAD also clears `lut_loaded`.
  - `abort` has priority over `start` and `cfg_we`.
- `cfg_we` outside RUN is ignored. `start` in LOAD, FLUSH or RUN is ignored.
- Sample counter clears on every entry to FLUSH.

## Timing
- Reset values:
  - State IDLE; `lut_addr`=0, `core_index`=0, `core_d`=0.
  - `core_fcw`=0, `core_offset`=0.
  - `core_rst_n`=0, `core_cen`=1, `core_wen`=1.
  - `sample_valid`=0, `sample_data`=0, `busy`=0, `done`=0, `lut_loaded`=0.
- All outputs are registered.
- `start` at cycle T with a full load:
  - LOAD from T+1; first `core_wen`=0 at T+2; last write (index 63) at T+65.
  - FLUSH at T+66; RUN from T+67.
- `start` with a skip-load: FLUSH at T+1, RUN from T+2.
- Capture latency: `core_wen_out` at cycle C gives `sample_valid` at C+1.
- `done` rises the cycle after the final `sample_valid`.
- `reset` mid-operation: next cycle all reset values, including `lut_loaded`=0.

## Structure
- Package `cordic_ctrl_pkg` holds:
  - the state enum;
  - `LUT_DEPTH`, `LUT_W`, `AMP_W`=16, `IDX_W`=6;
  - the active-low control-level constants for the core.
- One sub-module, `cordic_lut_walker`. It owns the address counter, the 1-cycle ROM-latency align register and the write-strobe generation. Its outputs are `wr_en`, `wr_idx`, `wr_data` and `last`.
- The FSM, retune registers and capture counter stay in the top module.

## Test plan
- Full load: `start`, ROM word i = {16'hA5A5, 32'(i)} → 64 writes, `core_index` 0..63, `core_d` matches each index, FLUSH pulse at T+66.
- Capture: `NUM_SAMPLES`=8, `core_wen_out` high every other cycle → exactly 8 `sample_valid` pulses with matching `core_amp` values, then `done`=1 and `core_cen`=1.
- Skip-load: after a completed run, `start`+`skip_load` → no `core_wen`=0 cycles, `core_rst_n`=0 at T+1, RUN at T+2.
- Abort mid-LOAD at index 30 → IDLE next cycle; a subsequent `start`+`skip_load` still performs a full load.
- Retune: `cfg_we` in RUN with `fcw_in`=16'h0222 → `core_fcw`=16'h0222 next cycle, no FLUSH; `cfg_we` in IDLE → `core_fcw` unchanged.
- Sync reset asserted in RUN with 5 samples captured → all reset values next cycle; a fresh `start` captures a full `NUM_SAMPLES` again.
